// File: rtl/fft_out_reorder.sv
// Reorders the 4-lane bit-reversed FFT output stream into natural bin order using a
// ping-pong pair of frame banks; one bank fills while the other drains.
module fft_out_reorder #(
  parameter int unsigned NBITS_out = 15,
  parameter int unsigned N         = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [2*NBITS_out-1:0] in0,
  input  logic [2*NBITS_out-1:0] in1,
  input  logic [2*NBITS_out-1:0] in2,
  input  logic [2*NBITS_out-1:0] in3,
  output logic                   out_valid,
  output logic                   out_frame_start,
  output logic [2*NBITS_out-1:0] out0,
  output logic [2*NBITS_out-1:0] out1,
  output logic [2*NBITS_out-1:0] out2,
  output logic [2*NBITS_out-1:0] out3
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned CW    = LOG2N - 2;
  localparam int unsigned W     = 2 * NBITS_out;
  localparam logic [CW-1:0] CntLast = CW'(N / 4 - 1);

  typedef enum logic {StIdle, StRead} state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] p);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < int'(LOG2N); i++) r[i] = p[int'(LOG2N) - 1 - i];
    return r;
  endfunction

  logic [W-1:0] mem [2*N];
  logic [W-1:0] in_lane [4];

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic          pbank_q, pbank_d;
  logic          rpend_q, rpend_d;
  logic          rpend_clr, wrap;
  logic          rd_en, rd_bank;
  logic [CW-1:0] rd_cnt;

  logic          valid_q, fs_q;
  logic [W-1:0]  out_q [4];

  assign in_lane[0] = in0;
  assign in_lane[1] = in1;
  assign in_lane[2] = in2;
  assign in_lane[3] = in3;

  // Lane l of write cycle c holds position 4c+l, i.e. bin bitrev(4c+l).
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int l = 0; l < 4; l++) begin
        mem[{wbank_q, bitrev({wcnt_q, 2'(l)})}] <= in_lane[l];
      end
    end
  end

  always_comb begin
    wrap    = in_valid && (wcnt_q == CntLast);
    wcnt_d  = in_valid ? wcnt_q + 1'b1 : wcnt_q;
    wbank_d = wrap ? ~wbank_q : wbank_q;
    pbank_d = wrap ? wbank_q : pbank_q;
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rbank_d   = rbank_q;
    rpend_clr = 1'b0;
    rd_en     = 1'b0;
    rd_bank   = rbank_q;
    rd_cnt    = rcnt_q;
    unique case (state_q)
      StIdle: begin
        // The take-over edge already emits quad 0 of the handed-over bank.
        if (rpend_q) begin
          rd_en     = 1'b1;
          rd_bank   = pbank_q;
          rd_cnt    = '0;
          rpend_clr = 1'b1;
          state_d   = StRead;
          rbank_d   = pbank_q;
          rcnt_d    = CW'(1);
        end
      end
      StRead: begin
        rd_en = 1'b1;
        if (rcnt_q == CntLast) begin
          rcnt_d = '0;
          if (rpend_q) begin
            rpend_clr = 1'b1;
            rbank_d   = pbank_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A new hand-over outranks consuming the previous one.
    rpend_d = wrap ? 1'b1 : (rpend_clr ? 1'b0 : rpend_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      pbank_q <= 1'b0;
      rpend_q <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      for (int l = 0; l < 4; l++) out_q[l] <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      pbank_q <= pbank_d;
      rpend_q <= rpend_d;
      valid_q <= rd_en;
      fs_q    <= rd_en && (rd_cnt == '0);
      for (int l = 0; l < 4; l++) begin
        out_q[l] <= rd_en ? mem[{rd_bank, rd_cnt, 2'(l)}] : '0;
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_frame_start = fs_q;
  assign out0            = out_q[0];
  assign out1            = out_q[1];
  assign out2            = out_q[2];
  assign out3            = out_q[3];

endmodule
